// File: rtl/ma_mem_controller.sv
// MA-stage data memory controller: issues one registered load/store per request and stalls the pipeline until it completes.
// Define MA_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with an err pulse instead of issuing them.
module ma_mem_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_func_3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_busywait,
    input  logic [31:0] i_mem_rdata,
    output logic        o_dm_read,
    output logic        o_dm_write,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    output logic [3:0]  o_dm_byte_en,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_count;
    logic        r_timeout;
    logic [2:0]  r_func_3;
    logic [1:0]  r_addr_lo;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_request;
    logic        w_misaligned;
    logic        w_legal_req;
    logic        w_timeout_hit;
    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_ext;

    assign w_is_byte = (i_func_3 == 3'b000) || (i_func_3 == 3'b100);
    assign w_is_half = (i_func_3 == 3'b001) || (i_func_3 == 3'b101);
    assign w_request = i_mem_read | i_mem_write;

`ifdef MA_ALIGN_CHECK_EN
    assign w_misaligned = (w_is_half && i_addr[0]) ||
                          (!w_is_byte && !w_is_half && (i_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_legal_req   = w_request && !w_misaligned;
    assign w_timeout_hit = i_mem_busywait && (({1'b0, r_count} + 9'd1) == TIMEOUT_LIM);

    always_comb begin
        w_byte_en = 4'b1111;
        w_wdata   = i_wdata;
        if (w_is_byte) begin
            w_byte_en = 4'b0001 << i_addr[1:0];
            w_wdata   = {4{i_wdata[7:0]}};
        end else if (w_is_half) begin
            w_byte_en = 4'b0011 << i_addr[1:0];
            w_wdata   = {2{i_wdata[15:0]}};
        end
    end

    // Lane select uses the captured address so the load result matches the issued access.
    always_comb begin
        w_rd_byte = i_mem_rdata[7:0];
        w_rd_half = i_mem_rdata[15:0];
        case (r_addr_lo)
            2'd1: begin
                w_rd_byte = i_mem_rdata[15:8];
                w_rd_half = i_mem_rdata[23:8];
            end
            2'd2: begin
                w_rd_byte = i_mem_rdata[23:16];
                w_rd_half = i_mem_rdata[31:16];
            end
            2'd3: begin
                w_rd_byte = i_mem_rdata[31:24];
                w_rd_half = {8'h00, i_mem_rdata[31:24]};
            end
            default: begin
                w_rd_byte = i_mem_rdata[7:0];
                w_rd_half = i_mem_rdata[15:0];
            end
        endcase
    end

    always_comb begin
        w_load_ext = i_mem_rdata;
        case (r_func_3)
            3'b000:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
            3'b100:  w_load_ext = {24'h000000, w_rd_byte};
            3'b001:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
            3'b101:  w_load_ext = {16'h0000, w_rd_half};
            default: w_load_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        o_stall      = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_legal_req) begin
                    w_next_state = ST_ACCESS;
                    o_stall      = 1'b1;
                end else if (w_request) begin
                    o_err = 1'b1;
                end
            end
            ST_ACCESS: begin
                o_stall = 1'b1;
                if (!i_mem_busywait || w_timeout_hit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                o_err        = r_timeout;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (i_reset) begin
            o_stall = 1'b0;
            o_err   = 1'b0;
        end
    end

    // load_data is only refreshed by loads; stores and timeouts leave it untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_count      <= 8'd0;
            r_timeout    <= 1'b0;
            r_func_3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            o_dm_read    <= 1'b0;
            o_dm_write   <= 1'b0;
            o_dm_addr    <= 32'h0;
            o_dm_wdata   <= 32'h0;
            o_dm_byte_en <= 4'b0000;
            o_load_data  <= 32'h0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_legal_req) begin
                        o_dm_read    <= i_mem_read && !i_mem_write;
                        o_dm_write   <= i_mem_write;
                        o_dm_addr    <= {i_addr[31:2], 2'b00};
                        o_dm_wdata   <= w_wdata;
                        o_dm_byte_en <= w_byte_en;
                        r_func_3     <= i_func_3;
                        r_addr_lo    <= i_addr[1:0];
                        r_count      <= 8'd0;
                        r_timeout    <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    r_count <= r_count + 8'd1;
                    if (!i_mem_busywait) begin
                        o_dm_read  <= 1'b0;
                        o_dm_write <= 1'b0;
                        if (o_dm_read) begin
                            o_load_data <= w_load_ext;
                        end
                    end else if (w_timeout_hit) begin
                        o_dm_read  <= 1'b0;
                        o_dm_write <= 1'b0;
                        r_timeout  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_timeout <= 1'b0;
                end
                default: begin
                    r_timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule
